stall_ctrl: RTL and testbench
=============================

# stall_ctrl

Pipeline stall and bubble controller for the five-stage MIPS core. It is the producer-side partner of the forwarding unit: forwarding resolves every hazard it can, and this block stalls D whenever a needed value is not yet available anywhere. It keeps a shadow pipeline of (destination, Tnew) for E and M, and a multiply/divide busy counter. It drives the IF/ID freeze and the ID/EX bubble.

## Interface

Parameters:
- MULT_CYCLES, 5: busy cycles after mult/multu issues into E.
- DIV_CYCLES, 10: busy cycles after div/divu issues into E.
- CNT_W, 4: counter width; must hold max(MULT_CYCLES, DIV_CYCLES).

Ports (the decoder supplies the per-instruction D-stage fields):
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  reset; one clock; asynchronous, active-low.
- rs_D, rt_D  in  5  source register fields of the instruction in D.
- tuse_rs_D, tuse_rt_D  in  2  cycles until the operand is consumed (0 = branch/jr, 1 = ALU, 2 = store data, 3 = unused).
- a3_D  in  5  destination register of the D instruction.
- rwe_D  in  1  D instruction writes the GPR file.
- tnew_D  in  2  Tnew on entry to E (0 = jal/link, 1 = ALU/mfhi/mflo, 2 = load).
- md_start_D  in  1  D instruction is mult/multu/div/divu.
- md_div_D  in  1  with md_start_D, selects DIV_CYCLES.
- md_use_D  in  1  D instruction is mfhi/mflo/mthi/mtlo.
- flush  in  1  exception/eret flush; kills D→E issue and clears shadow state.
- stall_D  out  1  freeze PC and IF/ID (combinational).
- bubble_E  out  1  load NOP into ID/EX: stall_D | flush (combinational).
- md_busy  out  1  multiply/divide counter nonzero.

## Operation

- The shadow registers are a3_e, we_e, tnew_e and a3_m, we_m, tnew_m.
- Issue occurs when !stall_D && !flush at a clock edge.
- On issue, the E shadow loads {a3_D, rwe_D, tnew_D}. Otherwise, the E shadow loads zeros (bubble).
- Each edge, M loads E with tnew_m = (tnew_e == 0) ? 0 : tnew_e − 1. When flush = 1, M loads zeros.
- An operand src (rs or rt) hazards when src != 0, tuse != 3, and either of these holds:
  - src == a3_e && we_e && tnew_e > tuse
  - src == a3_m && we_m && tnew_m > tuse
- The MD counter is md_cnt.
  - On issue with md_start_D = 1, it loads md_div_D ? DIV_CYCLES : MULT_CYCLES.
  - Otherwise it decrements when nonzero. It holds at 0.
  - flush does not clear it; an in-flight operation completes.
- md_busy = (md_cnt != 0).
- stall_D = rs hazard | rt hazard | ((md_start_D | md_use_D) & md_busy).
- All comparisons use full 5-bit register numbers; Tnew and Tuse are 2-bit unsigned.
- Simultaneous flush and hazard: bubble_E = 1; stall_D keeps its combinational value; no issue occurs.

## Timing

- Reset (asynchronous, rst_n low) zeros all shadow registers and md_cnt. While inputs are benign, stall_D = 0, bubble_E = 0, md_busy = 0. Release takes effect at the next rising edge.
- stall_D and bubble_E are zero-latency combinational outputs from the D inputs and the registered state. There is no registered output path.
- Load-use ALU stalls 1 cycle. Load-branch stalls 2 cycles. ALU-branch stalls 1 cycle.
- mult followed immediately by mflo stalls exactly MULT_CYCLES cycles. div followed by mflo stalls DIV_CYCLES cycles.
- Reset asserted mid-operation clears md_cnt immediately; md_busy drops asynchronously.

## Structure

- Shared package hazard_pkg:
  - TUSE_NONE = 2'd3
  - Tnew/Tuse encodings
  - default MULT_CYCLES / DIV_CYCLES
- Sub-module md_busy_counter (load value, load enable, count, busy) holds the MD counter. The shadow pipeline and compare logic stay in stall_ctrl.

## Test plan

- Load-use: lw into $1 (tnew_D = 2) issues, then add with rs = 1 (tuse = 1).
  - Required: stall_D = 1 for exactly 1 cycle, bubble_E = 1 that cycle, then issue.
- Load-branch: lw into $1, then beq with rs = 1 (tuse = 0).
  - Required: stall_D = 1 for 2 cycles.
  - Variant: replace lw with addu (tnew = 1). Required: 1 stall cycle.
- $0 and unused operands: lw into $0 then add reading $0; separately, lw into $5 then an instruction with tuse_rt = 3 and rt = 5.
  - Required: stall_D = 0 throughout.
- MD busy: mult issues, then mflo in D.
  - Required: md_busy = 1 and stall_D = 1 for 5 cycles; mflo issues on the 6th edge.
  - Repeat with div. Required: 10 cycles.
- Flush during stall: lw $1 in E, dependent add in D, flush = 1 for one cycle.
  - Required: bubble_E = 1; shadow cleared; stall_D = 0 the next cycle.
- Reset mid-div: drop rst_n when md_cnt = 7.
  - Required: md_busy = 0 immediately; after release a following mflo issues without stalling.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared hazard encodings for the stall/forwarding logic of the five-stage core.
// Tuse/Tnew codes, default multiply/divide latencies, and the shadow-stage record.
package hazard_pkg;

  localparam logic [1:0] TUSE_BR   = 2'd0;
  localparam logic [1:0] TUSE_ALU  = 2'd1;
  localparam logic [1:0] TUSE_ST   = 2'd2;
  localparam logic [1:0] TUSE_NONE = 2'd3;

  localparam logic [1:0] TNEW_LINK = 2'd0;
  localparam logic [1:0] TNEW_ALU  = 2'd1;
  localparam logic [1:0] TNEW_LOAD = 2'd2;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef struct packed {
    logic [4:0] a3;
    logic       we;
    logic [1:0] tnew;
  } shadow_t;

  // Tnew counts down one per stage and saturates at zero.
  function automatic logic [1:0] tnew_dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

endpackage

// File: rtl/md_busy_counter.sv
// Multiply/divide busy counter: loads the op latency on issue, counts down to zero.
// Busy is derived from the register so reset drops it asynchronously.
module md_busy_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             busy
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             r_cnt <= '0;
    else if (load)          r_cnt <= load_val;
    else if (r_cnt != '0)   r_cnt <= r_cnt - 1'b1;
  end

  assign busy = (r_cnt != '0);

endmodule

// File: rtl/stall_ctrl.sv
// Stall/bubble controller: tracks (dest, Tnew) for E and M and stalls D whenever
// an operand cannot be forwarded in time, or an HI/LO access meets a busy MD unit.
module stall_ctrl
  import hazard_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] rs_D,
  input  logic [4:0] rt_D,
  input  logic [1:0] tuse_rs_D,
  input  logic [1:0] tuse_rt_D,
  input  logic [4:0] a3_D,
  input  logic       rwe_D,
  input  logic [1:0] tnew_D,
  input  logic       md_start_D,
  input  logic       md_div_D,
  input  logic       md_use_D,
  input  logic       flush,
  output logic       stall_D,
  output logic       bubble_E,
  output logic       md_busy
);

  localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES);

  shadow_t r_e, r_m;
  shadow_t w_e_nxt, w_m_nxt;

  logic [1:0][4:0] w_src;
  logic [1:0][1:0] w_tuse;
  logic [1:0]      w_haz;
  logic            w_md_stall;
  logic            w_issue;

  assign w_src  = {rt_D, rs_D};
  assign w_tuse = {tuse_rt_D, tuse_rs_D};

  // Operand 0 is rs, operand 1 is rt; a hazard is a producer whose value is
  // still further away than the consumer's use point.
  for (genvar g = 0; g < 2; g++) begin : g_op
    assign w_haz[g] = (w_src[g] != 5'd0) && (w_tuse[g] != TUSE_NONE) &&
                      (((w_src[g] == r_e.a3) && r_e.we && (r_e.tnew > w_tuse[g])) ||
                       ((w_src[g] == r_m.a3) && r_m.we && (r_m.tnew > w_tuse[g])));
  end

  assign w_md_stall = (md_start_D | md_use_D) & md_busy;
  assign stall_D    = (|w_haz) | w_md_stall;
  assign bubble_E   = stall_D | flush;
  assign w_issue    = !stall_D && !flush;

  always_comb begin
    w_e_nxt = '0;
    if (w_issue) w_e_nxt = '{a3: a3_D, we: rwe_D, tnew: tnew_D};
    w_m_nxt = '0;
    if (!flush)  w_m_nxt = '{a3: r_e.a3, we: r_e.we, tnew: tnew_dec(r_e.tnew)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_e <= '0;
      r_m <= '0;
    end else begin
      r_e <= w_e_nxt;
      r_m <= w_m_nxt;
    end
  end

  // Flush does not reach the counter: an in-flight mult/div still completes.
  md_busy_counter #(.CNT_W(CNT_W)) u_md (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_issue & md_start_D),
    .load_val (md_div_D ? DIV_LD : MULT_LD),
    .busy     (md_busy)
  );

endmodule

// File: tb/tb_stall_ctrl.sv
// Directed bench for stall_ctrl: expectations are queued when a D instruction is
// presented and popped/compared mid-cycle against the combinational outputs.
module tb_stall_ctrl;
  import hazard_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs_D, rt_D, a3_D;
  logic [1:0] tuse_rs_D, tuse_rt_D, tnew_D;
  logic       rwe_D, md_start_D, md_div_D, md_use_D, flush;
  logic       stall_D, bubble_E, md_busy;

  typedef struct packed {
    logic stall;
    logic bubble;
    logic busy;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs_D(rs_D), .rt_D(rt_D), .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D),
    .a3_D(a3_D), .rwe_D(rwe_D), .tnew_D(tnew_D),
    .md_start_D(md_start_D), .md_div_D(md_div_D), .md_use_D(md_use_D),
    .flush(flush), .stall_D(stall_D), .bubble_E(bubble_E), .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish (tests=%0d fails=%0d)", tests, fails);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input string sig, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s %s observed=%b expected=%b", tag, sig, obs, exp);
    end
  endtask

  task automatic ins(input logic [4:0] rs, input logic [1:0] trs,
                     input logic [4:0] rt, input logic [1:0] trt,
                     input logic [4:0] a3, input logic we, input logic [1:0] tn,
                     input logic mds, input logic mdd, input logic mdu, input logic fl);
    rs_D = rs; tuse_rs_D = trs; rt_D = rt; tuse_rt_D = trt;
    a3_D = a3; rwe_D = we; tnew_D = tn;
    md_start_D = mds; md_div_D = mdd; md_use_D = mdu; flush = fl;
  endtask

  task automatic nop();
    ins(5'd0, TUSE_NONE, 5'd0, TUSE_NONE, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // One pipeline cycle: queue the expectation, compare mid-cycle, cross the edge.
  task automatic cyc(input string tag, input logic s, input logic b, input logic m);
    exp_t e;
    exp_q.push_back('{stall: s, bubble: b, busy: m});
    @(negedge clk);
    e = exp_q.pop_front();
    chk(tag, "stall_D", stall_D, e.stall);
    chk(tag, "bubble_E", bubble_E, e.bubble);
    chk(tag, "md_busy", md_busy, e.busy);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    nop(); cyc("drain", 1'b0, 1'b0, 1'b0);
    nop(); cyc("drain", 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    nop();
    #1;
    chk("reset", "stall_D", stall_D, 1'b0);
    chk("reset", "bubble_E", bubble_E, 1'b0);
    chk("reset", "md_busy", md_busy, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Load-use ALU: one stall
    ins(5'd2, TUSE_ALU, 5'd0, TUSE_NONE, 5'd1, 1'b1, TNEW_LOAD, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("lu_lw", 1'b0, 1'b0, 1'b0);
    ins(5'd1, TUSE_ALU, 5'd0, TUSE_NONE, 5'd3, 1'b1, TNEW_ALU, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("lu_stall", 1'b1, 1'b1, 1'b0);
    cyc("lu_issue", 1'b0, 1'b0, 1'b0);
    drain();

    // Load-branch: two stalls
    ins(5'd2, TUSE_ALU, 5'd0, TUSE_NONE, 5'd1, 1'b1, TNEW_LOAD, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("lb_lw", 1'b0, 1'b0, 1'b0);
    ins(5'd1, TUSE_BR, 5'd0, TUSE_BR, 5'd0, 1'b0, TNEW_LINK, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("lb_stall1", 1'b1, 1'b1, 1'b0);
    cyc("lb_stall2", 1'b1, 1'b1, 1'b0);
    cyc("lb_issue", 1'b0, 1'b0, 1'b0);
    drain();

    // ALU-branch: one stall
    ins(5'd2, TUSE_ALU, 5'd4, TUSE_ALU, 5'd1, 1'b1, TNEW_ALU, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("ab_addu", 1'b0, 1'b0, 1'b0);
    ins(5'd1, TUSE_BR, 5'd0, TUSE_BR, 5'd0, 1'b0, TNEW_LINK, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("ab_stall", 1'b1, 1'b1, 1'b0);
    cyc("ab_issue", 1'b0, 1'b0, 1'b0);
    drain();

    // rt path: load then a consumer of rt at ALU time
    ins(5'd2, TUSE_ALU, 5'd0, TUSE_NONE, 5'd7, 1'b1, TNEW_LOAD, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("rt_lw", 1'b0, 1'b0, 1'b0);
    ins(5'd0, TUSE_NONE, 5'd7, TUSE_ALU, 5'd9, 1'b1, TNEW_ALU, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("rt_stall", 1'b1, 1'b1, 1'b0);
    cyc("rt_issue", 1'b0, 1'b0, 1'b0);
    drain();

    // $0 destination never hazards
    ins(5'd2, TUSE_ALU, 5'd0, TUSE_NONE, 5'd0, 1'b1, TNEW_LOAD, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("z_lw", 1'b0, 1'b0, 1'b0);
    ins(5'd0, TUSE_ALU, 5'd0, TUSE_ALU, 5'd3, 1'b1, TNEW_ALU, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("z_add", 1'b0, 1'b0, 1'b0);
    drain();

    // Unused rt operand matching a load destination
    ins(5'd2, TUSE_ALU, 5'd0, TUSE_NONE, 5'd5, 1'b1, TNEW_LOAD, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("u_lw", 1'b0, 1'b0, 1'b0);
    ins(5'd6, TUSE_ALU, 5'd5, TUSE_NONE, 5'd8, 1'b1, TNEW_ALU, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("u_ins", 1'b0, 1'b0, 1'b0);
    drain();

    // mult then mflo: five busy stalls, issue on the sixth edge
    ins(5'd2, TUSE_ALU, 5'd3, TUSE_ALU, 5'd0, 1'b0, TNEW_LINK, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("mult", 1'b0, 1'b0, 1'b0);
    ins(5'd0, TUSE_NONE, 5'd0, TUSE_NONE, 5'd8, 1'b1, TNEW_ALU, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cyc("mult_busy", 1'b1, 1'b1, 1'b1);
    cyc("mult_mflo", 1'b0, 1'b0, 1'b0);
    drain();

    // div then mflo: ten busy stalls
    ins(5'd2, TUSE_ALU, 5'd3, TUSE_ALU, 5'd0, 1'b0, TNEW_LINK, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc("div", 1'b0, 1'b0, 1'b0);
    ins(5'd0, TUSE_NONE, 5'd0, TUSE_NONE, 5'd8, 1'b1, TNEW_ALU, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) cyc("div_busy", 1'b1, 1'b1, 1'b1);
    cyc("div_mflo", 1'b0, 1'b0, 1'b0);
    drain();

    // Flush during a load-use stall clears the shadow
    ins(5'd2, TUSE_ALU, 5'd0, TUSE_NONE, 5'd1, 1'b1, TNEW_LOAD, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("fl_lw", 1'b0, 1'b0, 1'b0);
    ins(5'd1, TUSE_BR, 5'd0, TUSE_NONE, 5'd0, 1'b0, TNEW_LINK, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc("fl_stall", 1'b1, 1'b1, 1'b0);
    flush = 1'b0;
    cyc("fl_after", 1'b0, 1'b0, 1'b0);
    drain();

    // Flush with no hazard: bubble only, nothing issues into E
    ins(5'd2, TUSE_ALU, 5'd0, TUSE_NONE, 5'd1, 1'b1, TNEW_LOAD, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc("fl_only", 1'b0, 1'b1, 1'b0);
    ins(5'd1, TUSE_ALU, 5'd0, TUSE_NONE, 5'd3, 1'b1, TNEW_ALU, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("fl_killed", 1'b0, 1'b0, 1'b0);
    drain();

    // Flush does not stop an in-flight multiply
    ins(5'd2, TUSE_ALU, 5'd3, TUSE_ALU, 5'd0, 1'b0, TNEW_LINK, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("mfl_mult", 1'b0, 1'b0, 1'b0);
    nop(); flush = 1'b1;
    cyc("mfl_flush", 1'b0, 1'b1, 1'b1);
    nop();
    for (int i = 0; i < 4; i++) cyc("mfl_count", 1'b0, 1'b0, 1'b1);
    cyc("mfl_done", 1'b0, 1'b0, 1'b0);

    // Reset mid-divide with the counter at 7
    ins(5'd2, TUSE_ALU, 5'd3, TUSE_ALU, 5'd0, 1'b0, TNEW_LINK, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc("rd_div", 1'b0, 1'b0, 1'b0);
    nop();
    for (int i = 0; i < 3; i++) cyc("rd_count", 1'b0, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rd_async", "md_busy", md_busy, 1'b0);
    ins(5'd0, TUSE_NONE, 5'd0, TUSE_NONE, 5'd8, 1'b1, TNEW_ALU, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("rd_in_reset", 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    cyc("rd_mflo", 1'b0, 1'b0, 1'b0);
    cyc("rd_mflo2", 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
